round_robin_decode_arbiter: RTL and testbench

ROUND_ROBIN_DECODE_ARBITER -- requirements
Module: round_robin_decode_arbiter

---
 rtl/round_robin_decode_arbiter.sv | 150 +++++++++++++++
 tb/tb_round_robin_decode_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/round_robin_decode_arbiter.sv
// round_robin_decode_arbiter
//
// Purpose:
//   Eight-way round-robin arbiter for a single shared resource. One
//   requester at a time owns the resource. Ownership ends when the owner
//   signals done, drops its request, or has held the resource for MAX_HOLD
//   cycles; in that last case a one-cycle timeout pulse is raised. Every
//   grant is followed by at least one idle cycle, and the search for the
//   next owner starts just above the previous owner, so requesters are
//   served fairly.
//
// Parameters:
//   MAX_HOLD     longest grant in clock cycles (1..15)
//
// Ports:
//   clock        rising-edge clock
//   resetn       synchronous active-low reset
//   req_in[7:0]  level-sensitive request lines, bit i = requester i
//   done_in      owner releases the resource (only looked at while granted)
//   grant_out    one-hot grant, all zero when nobody owns the resource
//   grant_id     binary index of the owner, 0 when nobody owns it
//   grant_valid  high while the resource is granted
//   timeout_out  one-cycle pulse in the idle cycle after a forced release

module round_robin_decode_arbiter #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] req_in,
  input  logic       done_in,
  output logic [7:0] grant_out,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic       timeout_out
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // Counter value reached in the final allowed grant cycle.
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state, state_next;
  logic [3:0] hold_cnt, hold_next;
  logic [2:0] last_id, last_next;
  logic [2:0] id_next;
  logic [7:0] out_next;
  logic       valid_next;
  logic       timeout_next;

  logic [2:0] winner;
  logic       expire;
  logic       release_now;

  // Walk upward from the slot just above the previous owner. The 3-bit add
  // wraps 7 -> 0 on its own; the eighth step lands back on last_id so the
  // previous owner is considered only after everyone else.
  function automatic logic [2:0] pick_winner(input logic [7:0] req,
                                             input logic [2:0] last);
    logic [2:0] idx;
    logic       found;
    pick_winner = 3'd0;
    found       = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = last + 3'(k);
      if (!found && req[idx]) begin
        pick_winner = idx;
        found       = 1'b1;
      end
    end
  endfunction

  assign winner = pick_winner(req_in, last_id);

  // Release conditions while granted. A forced release only counts as a
  // timeout when the owner neither finished nor dropped its request.
  assign expire      = (hold_cnt == HOLD_LAST);
  assign release_now = done_in || !req_in[grant_id] || expire;

  // State and all outputs are registered; reset wins over everything.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      grant_out   <= 8'h00;
      grant_id    <= 3'd0;
      grant_valid <= 1'b0;
      timeout_out <= 1'b0;
      hold_cnt    <= 4'd0;
      last_id     <= 3'd7;
    end else begin
      state       <= state_next;
      grant_out   <= out_next;
      grant_id    <= id_next;
      grant_valid <= valid_next;
      timeout_out <= timeout_next;
      hold_cnt    <= hold_next;
      last_id     <= last_next;
    end
  end

  // Next-state and next-output logic. The timeout pulse defaults low so it
  // lasts only the single idle cycle following a forced release.
  always_comb begin
    state_next   = state;
    out_next     = grant_out;
    id_next      = grant_id;
    valid_next   = grant_valid;
    timeout_next = 1'b0;
    hold_next    = hold_cnt;
    last_next    = last_id;

    case (state)
      IDLE: begin
        if (req_in != 8'h00) begin
          state_next = GRANT;
          id_next    = winner;
          out_next   = 8'b1 << winner;
          valid_next = 1'b1;
          hold_next  = 4'd0;
          last_next  = winner;
        end
      end

      GRANT: begin
        if (release_now) begin
          state_next   = IDLE;
          id_next      = 3'd0;
          out_next     = 8'h00;
          valid_next   = 1'b0;
          hold_next    = 4'd0;
          timeout_next = expire && !done_in && req_in[grant_id];
        end else begin
          hold_next = hold_cnt + 4'd1;
        end
      end

      default: begin
        state_next = IDLE;
        id_next    = 3'd0;
        out_next   = 8'h00;
        valid_next = 1'b0;
        hold_next  = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_round_robin_decode_arbiter.sv
// tb_round_robin_decode_arbiter
//
// Purpose:
//   Self-checking bench for round_robin_decode_arbiter. A behavioural model
//   tracks who owns the resource and for how many cycles; a compare process
//   checks every DUT output against it on each falling edge. Directed
//   scenarios add literal expectations that pin the model.

module tb_round_robin_decode_arbiter;

  localparam int MH = 15;

  logic       clock;
  logic       resetn;
  logic [7:0] req_in;
  logic       done_in;
  logic [7:0] grant_out;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       timeout_out;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Model state: owner is -1 when idle, held counts grant cycles from 1.
  int owner = -1;
  int held  = 0;
  int last  = 7;
  bit tmo   = 1'b0;

  round_robin_decode_arbiter #(
    .MAX_HOLD(MH)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .req_in      (req_in),
    .done_in     (done_in),
    .grant_out   (grant_out),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .timeout_out (timeout_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [7:0] actual,
                              input logic [7:0] required);
    n_compared++;
    if (actual !== required) begin
      n_mismatched++;
      $display("[TB] FAIL %s at %0t: actual=%0h required=%0h", name, $time,
               actual, required);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic rn, input logic [7:0] rq,
                                input logic dn);
    resetn  = rn;
    req_in  = rq;
    done_in = dn;
  endtask

  // Ownership model, advanced with the inputs seen at each rising edge.
  always @(posedge clock) begin
    bit gone, timed_out;
    int c;
    if (!resetn) begin
      owner = -1;
      held  = 0;
      last  = 7;
      tmo   = 1'b0;
    end else if (owner < 0) begin
      tmo = 1'b0;
      if (req_in != 8'h00) begin
        for (int k = 1; k <= 8; k++) begin
          c = (last + k) % 8;
          if (req_in[c]) break;
        end
        owner = c;
        last  = c;
        held  = 1;
      end
    end else begin
      gone      = done_in || !req_in[owner];
      timed_out = (held >= MH);
      if (gone || timed_out) begin
        tmo   = timed_out && !gone;
        owner = -1;
        held  = 0;
      end else begin
        held = held + 1;
      end
    end
  end

  // Per-cycle comparison against the model on the falling edge.
  always @(negedge clock) begin
    logic [7:0] exp_out;
    logic [7:0] exp_id;
    exp_out = (owner >= 0) ? (8'h01 << owner) : 8'h00;
    exp_id  = (owner >= 0) ? 8'(owner) : 8'h00;
    check_output("model_grant_out", grant_out, exp_out);
    check_output("model_grant_id", {5'd0, grant_id}, exp_id);
    check_output("model_grant_valid", {7'd0, grant_valid}, {7'd0, owner >= 0});
    check_output("model_timeout", {7'd0, timeout_out}, {7'd0, tmo});
  end

  initial begin
    apply_stimulus(1'b0, 8'h00, 1'b0);
    tick(2);
    check_output("reset_grant_out", grant_out, 8'h00);
    check_output("reset_grant_id", {5'd0, grant_id}, 8'h00);
    check_output("reset_valid", {7'd0, grant_valid}, 8'h00);
    check_output("reset_timeout", {7'd0, timeout_out}, 8'h00);

    // Single requester 0, done on third grant cycle, then re-grant after gap.
    apply_stimulus(1'b1, 8'h01, 1'b0);
    tick(1);
    check_output("r0_grant_out", grant_out, 8'h01);
    check_output("r0_valid", {7'd0, grant_valid}, 8'h01);
    tick(2);
    apply_stimulus(1'b1, 8'h01, 1'b1);
    tick(1);
    check_output("r0_released", {7'd0, grant_valid}, 8'h00);
    check_output("r0_released_out", grant_out, 8'h00);
    apply_stimulus(1'b1, 8'h01, 1'b0);
    tick(1);
    check_output("r0_regrant", {7'd0, grant_valid}, 8'h01);
    apply_stimulus(1'b1, 8'h00, 1'b0);
    tick(3);

    // All requesting with done held: ids 0..7,0 split by idle cycles.
    apply_stimulus(1'b0, 8'h00, 1'b0);
    tick(1);
    apply_stimulus(1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 18; i++) begin
      tick(1);
      if (i % 2 == 0) begin
        check_output("rr_id", {5'd0, grant_id}, 8'((i / 2) % 8));
        check_output("rr_valid", {7'd0, grant_valid}, 8'h01);
      end else begin
        check_output("rr_gap", {7'd0, grant_valid}, 8'h00);
      end
    end

    // Requesters 2 and 5 never finish: each held MH cycles then timed out.
    apply_stimulus(1'b1, 8'h24, 1'b0);
    for (int c = 0; c < MH; c++) begin
      tick(1);
      check_output("hold2_id", {5'd0, grant_id}, 8'h02);
    end
    tick(1);
    check_output("hold2_timeout", {7'd0, timeout_out}, 8'h01);
    check_output("hold2_idle", {7'd0, grant_valid}, 8'h00);
    for (int c = 0; c < MH; c++) begin
      tick(1);
      check_output("hold5_id", {5'd0, grant_id}, 8'h05);
    end
    tick(1);
    check_output("hold5_timeout", {7'd0, timeout_out}, 8'h01);
    apply_stimulus(1'b1, 8'h00, 1'b0);
    tick(1);
    check_output("timeout_one_cycle", {7'd0, timeout_out}, 8'h00);
    tick(1);

    // Owner 3 drops its request while 6 is waiting.
    apply_stimulus(1'b0, 8'h00, 1'b0);
    tick(1);
    apply_stimulus(1'b1, 8'h08, 1'b0);
    tick(1);
    check_output("drop_id3", {5'd0, grant_id}, 8'h03);
    apply_stimulus(1'b1, 8'h40, 1'b0);
    tick(1);
    check_output("drop_idle", {7'd0, grant_valid}, 8'h00);
    check_output("drop_no_timeout", {7'd0, timeout_out}, 8'h00);
    tick(1);
    check_output("drop_id6", {5'd0, grant_id}, 8'h06);
    check_output("drop_out6", grant_out, 8'h40);
    apply_stimulus(1'b1, 8'h00, 1'b0);
    tick(2);

    // done coincides with the last allowed cycle: no timeout pulse.
    apply_stimulus(1'b1, 8'h01, 1'b0);
    tick(MH);
    check_output("done_last_owner", {7'd0, grant_valid}, 8'h01);
    apply_stimulus(1'b1, 8'h01, 1'b1);
    tick(1);
    check_output("done_last_released", {7'd0, grant_valid}, 8'h00);
    check_output("done_last_no_timeout", {7'd0, timeout_out}, 8'h00);
    apply_stimulus(1'b1, 8'h00, 1'b0);
    tick(2);

    // Reset in the fifth grant cycle of requester 4.
    apply_stimulus(1'b1, 8'h10, 1'b0);
    tick(5);
    check_output("rst_mid_id4", {5'd0, grant_id}, 8'h04);
    apply_stimulus(1'b0, 8'h10, 1'b0);
    tick(1);
    check_output("rst_mid_out", grant_out, 8'h00);
    check_output("rst_mid_valid", {7'd0, grant_valid}, 8'h00);
    check_output("rst_mid_timeout", {7'd0, timeout_out}, 8'h00);
    apply_stimulus(1'b1, 8'h10, 1'b0);
    tick(1);
    check_output("rst_after_id4", {5'd0, grant_id}, 8'h04);
    check_output("rst_after_valid", {7'd0, grant_valid}, 8'h01);
    apply_stimulus(1'b1, 8'h00, 1'b1);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared,
             n_mismatched);
    $finish;
  end

endmodule
